// File: rtl/norm_pkg.sv
// Shared types and defaults for the norm sequencer.
package norm_pkg;

    localparam int BW  = 4;
    localparam int LEN = 8;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_DIV_ISSUE = 3'd1,
        ST_DIV_WAIT  = 3'd2,
        ST_EMIT      = 3'd3,
        ST_CLEAR     = 3'd4
    } state_e;

    localparam logic [2:0] LOAD      = ST_LOAD;
    localparam logic [2:0] DIV_ISSUE = ST_DIV_ISSUE;
    localparam logic [2:0] DIV_WAIT  = ST_DIV_WAIT;
    localparam logic [2:0] EMIT      = ST_EMIT;
    localparam logic [2:0] CLEAR     = ST_CLEAR;

    function automatic int result_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/norm_seq.sv
// Loads a sample vector into norm, then requests and forwards one normalized
// result per sample, clearing norm once the last result has been taken.
module norm_seq
    import norm_pkg::*;
#(
    parameter int bw  = BW,
    parameter int len = LEN,
    parameter int cw  = $clog2(len + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [bw-1:0]                 s_data,
    input  logic                          s_last,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [result_width(bw)-1:0]   m_data,
    output logic                          m_last,
    output logic                          n_wr,
    output logic [bw-1:0]                 n_in,
    output logic                          n_div,
    input  logic                          n_full,
    input  logic                          n_ready,
    input  logic [result_width(bw)-1:0]   n_out,
    output logic                          n_clr,
    output logic                          busy
);

    localparam logic [cw-1:0] last_cnt = cw'(len - 1);

    logic [2:0]    state;
    logic [cw-1:0] cnt;
    logic [cw-1:0] nvec;
    logic [cw-1:0] idx;
    logic          nz;
    logic          wait_first;

    always_comb begin
        s_ready = !reset && (state == LOAD) && !n_full;
        n_wr    = s_valid && s_ready;
        n_in    = s_data;
        n_div   = !reset && (state == DIV_ISSUE) && n_ready;
        n_clr   = !reset && (state == CLEAR);
        busy    = !reset && !((state == LOAD) && (cnt == '0));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= LOAD;
            cnt        <= '0;
            nvec       <= '0;
            idx        <= '0;
            nz         <= 1'b0;
            wait_first <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_last     <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (n_wr) begin
                        cnt <= cnt + 1'b1;
                        nz  <= nz | (s_data != '0);
                        if (s_last || (cnt == last_cnt)) begin
                            nvec  <= cnt + 1'b1;
                            idx   <= '0;
                            state <= DIV_ISSUE;
                        end
                    end
                end
                DIV_ISSUE: begin
                    if (n_ready) begin
                        wait_first <= 1'b1;
                        state      <= DIV_WAIT;
                    end
                end
                DIV_WAIT: begin
                    // n_ready can still be stale-high the cycle right after the pulse
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (n_ready) begin
                        m_data  <= nz ? n_out : '0;
                        m_last  <= (idx == nvec - 1'b1);
                        m_valid <= 1'b1;
                        state   <= EMIT;
                    end
                end
                EMIT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        idx     <= idx + 1'b1;
                        state   <= m_last ? CLEAR : DIV_ISSUE;
                    end
                end
                CLEAR: begin
                    cnt   <= '0;
                    nz    <= 1'b0;
                    state <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_norm_seq.sv
// Bench for norm_seq paired with a behavioural norm model; results are
// scoreboarded against value*2^(2*bw)/sum computed per vector.
`timescale 1ns/1ps
module tb_norm_seq;

    localparam int LEN_T = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;
    logic       n_wr;
    logic [3:0] n_in;
    logic       n_div;
    logic       n_full;
    logic       n_ready = 1'b1;
    logic [7:0] n_out = '0;
    logic       n_clr;
    logic       busy;

    always #5 clk = ~clk;

    norm_seq #(.bw(4), .len(LEN_T)) dut (
        .clk(clk), .reset(reset),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .n_wr(n_wr), .n_in(n_in), .n_div(n_div), .n_full(n_full),
        .n_ready(n_ready), .n_out(n_out), .n_clr(n_clr), .busy(busy)
    );

    int compared = 0;
    int mismatched = 0;

    task automatic check(input string name, input longint act, input longint exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural norm model ----------------
    logic       force_full = 1'b0;
    logic       wr_s = 1'b0, div_s = 1'b0, clr_s = 1'b0, rst_s = 1'b1;
    logic [3:0] in_s = '0;
    int         div_cnt = 0, clr_cnt = 0;
    int         fifo[$];
    int         nsum = 0, lat = 0, pend = 0, fcount = 0;
    bit         stale = 1'b0;

    assign n_full = force_full || (fcount >= LEN_T);

    function automatic logic [7:0] model_out(input int x, input int sum);
        int v;
        if (sum == 0) return 8'hFF;
        v = (x * 256) / sum;
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    always @(negedge clk) begin
        #1;
        wr_s = n_wr; in_s = n_in; div_s = n_div; clr_s = n_clr; rst_s = reset;
        if (n_div) div_cnt++;
        if (n_clr) clr_cnt++;
    end

    always @(posedge clk) begin
        if (rst_s || clr_s) begin
            fifo.delete();
            nsum = 0; lat = 0; stale = 1'b0;
            fcount  <= 0;
            n_ready <= 1'b1;
            n_out   <= '0;
        end else begin
            if (wr_s) begin
                fifo.push_back(int'(in_s));
                nsum += int'(in_s);
            end
            if (div_s) begin
                pend  = (fifo.size() > 0) ? fifo.pop_front() : 0;
                lat   = $urandom_range(2, 5);
                stale = ($urandom_range(0, 1) == 1);
                if (!stale) n_ready <= 1'b0;
            end else if (lat > 0) begin
                if (stale) begin
                    n_ready <= 1'b0;
                    stale = 1'b0;
                end
                lat--;
                if (lat == 0) begin
                    n_out   <= model_out(pend, nsum);
                    n_ready <= 1'b1;
                end
            end
            fcount <= fifo.size();
        end
    end

    // ---------------- downstream ready ----------------
    bit hold_m = 1'b0;
    always @(posedge clk) begin
        #1;
        m_ready = hold_m ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // ---------------- scoreboard monitor ----------------
    typedef struct { logic [7:0] data; logic last; } exp_t;
    exp_t exp_q[$];
    exp_t got_e;

    always @(negedge clk) begin
        #2;
        if (!reset && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_result: got data %0d, expected no result", m_data);
            end else begin
                got_e = exp_q.pop_front();
                check("m_data", m_data, got_e.data);
                check("m_last", m_last, got_e.last);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [3:0] vbuf[LEN_T];

    task automatic push_expect(input int n);
        int sum;
        exp_t e;
        sum = 0;
        for (int i = 0; i < n; i++) sum += int'(vbuf[i]);
        for (int i = 0; i < n; i++) begin
            if (sum == 0) e.data = 8'd0;
            else e.data = ((int'(vbuf[i]) * 256) / sum > 255) ? 8'd255
                                                             : 8'((int'(vbuf[i]) * 256) / sum);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send(input int n, input bit mark_last);
        bit ok;
        int g;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = vbuf[i];
            s_last  = mark_last && (i == n - 1);
            g = 0;
            forever begin
                #1;
                ok = s_ready;
                @(posedge clk);
                if (ok) break;
                g++;
                if (g > 500) begin
                    compared++;
                    mismatched++;
                    $display("FAIL send_timeout: sample %0d not accepted, expected accept within 500 cycles", i);
                    break;
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_vec(input int n, input bit mark_last);
        int d0, c0, g;
        d0 = div_cnt;
        c0 = clr_cnt;
        push_expect(n);
        send(n, mark_last);
        #3;
        check("busy_after_load", busy, 1);
        g = 0;
        while (clr_cnt == c0 && g < 3000) begin
            @(negedge clk); #3;
            g++;
        end
        @(negedge clk); #3;
        check("clr_pulses", clr_cnt - c0, 1);
        check("div_pulses", div_cnt - d0, n);
        check("results_drained", exp_q.size(), 0);
        check("idle_busy", busy, 0);
        check("idle_s_ready", s_ready, 1);
    endtask

    task automatic check_reset_values();
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_n_wr", n_wr, 0);
        check("rst_n_div", n_div, 0);
        check("rst_n_clr", n_clr, 0);
        check("rst_busy", busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int n, g, d0;
        logic [7:0] rec;
        bit mark;

        repeat (2) @(negedge clk);
        #3;
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;
        #3;
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_busy", busy, 0);

        vbuf[0] = 4'd1; vbuf[1] = 4'd2; vbuf[2] = 4'd3; vbuf[3] = 4'd2;
        run_vec(4, 1'b1);
        vbuf[0] = 4'd7; vbuf[1] = 4'd1;
        run_vec(2, 1'b1);
        vbuf[0] = 4'd4; vbuf[1] = 4'd4;
        run_vec(2, 1'b1);
        vbuf[0] = 4'd0; vbuf[1] = 4'd0; vbuf[2] = 4'd0;
        run_vec(3, 1'b1);
        vbuf[0] = 4'd9; vbuf[1] = 4'd5; vbuf[2] = 4'd1; vbuf[3] = 4'd6;
        run_vec(4, 1'b0);

        // downstream backpressure on the first result
        vbuf[0] = 4'd3; vbuf[1] = 4'd5; vbuf[2] = 4'd8;
        @(negedge clk);
        hold_m = 1'b1;
        fork
            run_vec(3, 1'b1);
            begin
                g = 0;
                do begin @(negedge clk); #3; g++; end while (!m_valid && g < 200);
                check("bp_valid_seen", m_valid, 1);
                rec = m_data;
                d0  = div_cnt;
                repeat (10) begin
                    @(negedge clk); #3;
                    check("bp_m_valid", m_valid, 1);
                    check("bp_m_data", m_data, rec);
                    check("bp_no_div", div_cnt, d0);
                end
                hold_m = 1'b0;
            end
        join

        // norm reports full while idle in LOAD
        vbuf[0] = 4'd2; vbuf[1] = 4'd6; vbuf[2] = 4'd1; vbuf[3] = 4'd3;
        @(negedge clk);
        force_full = 1'b1;
        fork
            run_vec(4, 1'b1);
            begin
                repeat (5) begin
                    @(negedge clk); #3;
                    check("full_s_ready", s_ready, 0);
                    check("full_n_wr", n_wr, 0);
                end
                @(negedge clk);
                force_full = 1'b0;
            end
        join

        // reset while waiting on the second element's result
        vbuf[0] = 4'd3; vbuf[1] = 4'd1; vbuf[2] = 4'd2; vbuf[3] = 4'd1;
        d0 = div_cnt;
        push_expect(4);
        send(4, 1'b1);
        g = 0;
        while (div_cnt < d0 + 2 && g < 2000) begin
            @(negedge clk); #3;
            g++;
        end
        check("second_div_seen", div_cnt - d0, 2);
        @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk); #3;
        check_reset_values();
        @(negedge clk);
        reset = 1'b0;
        #3;
        check("after_abort_busy", busy, 0);
        check("after_abort_s_ready", s_ready, 1);
        vbuf[0] = 4'd2; vbuf[1] = 4'd2;
        run_vec(2, 1'b1);

        // randomized vectors
        for (int v = 0; v < 30; v++) begin
            n = $urandom_range(1, LEN_T);
            for (int i = 0; i < LEN_T; i++) vbuf[i] = 4'd0;
            if ($urandom_range(0, 4) != 0)
                for (int i = 0; i < n; i++) vbuf[i] = 4'($urandom_range(0, 15));
            mark = (n < LEN_T) ? 1'b1 : ($urandom_range(0, 1) == 1);
            run_vec(n, mark);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
